// File: rtl/platform_ram_tester.sv
// Power-on RAM self-test master: writes an address-derived pattern to every word of the
// on-chip RAM through its Avalon-MM s1 port, reads it back and reports the mismatches.
module platform_ram_tester #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic                  clken,
  input  logic [DATA_W-1:0]     readdata,
  output logic [2:0]            dbg_state
);

  // Handshake: start is a one-cycle request, accepted only in IDLE when no done pulse is
  // showing; busy marks acceptance until done. The RAM side is zero-wait (no waitrequest):
  // every cycle with chipselect high is one completed transfer, and read data returns
  // exactly READ_LATENCY cycles after the read is on the bus.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_W-1:0]  A_LAST     = {ADDR_W{1'b1}};
  localparam logic [ERR_W-1:0]   ERR_MAX    = {ERR_W{1'b1}};
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LATENCY - 1);

  state_t                              state_q, state_d;
  logic [ADDR_W-1:0]                   a_q, a_d;
  logic [DATA_W-1:0]                   seed_q, seed_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                pass_q, pass_d;
  logic [ERR_W-1:0]                    err_q, err_d;
  logic [ADDR_W-1:0]                   first_q, first_d;
  logic [DRAIN_W-1:0]                  drain_q, drain_d;
  logic [READ_LATENCY-1:0]             dl_vld_q, dl_vld_d;
  logic [READ_LATENCY-1:0][ADDR_W-1:0] dl_addr_q, dl_addr_d;

  logic              accept;
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;

  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a);
    return s ^ DATA_W'(64'(a) * 64'h9E37_79B1);
  endfunction

  assign accept   = (state_q == S_IDLE) && start && !done_q;
  assign cmp_vld  = dl_vld_q[READ_LATENCY-1];
  assign cmp_addr = dl_addr_q[READ_LATENCY-1];
  assign mismatch = cmp_vld && (readdata != pattern(seed_q, cmp_addr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      seed_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
      drain_q   <= '0;
      dl_vld_q  <= '0;
      dl_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      seed_q    <= seed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      first_q   <= first_d;
      drain_q   <= drain_d;
      dl_vld_q  <= dl_vld_d;
      dl_addr_q <= dl_addr_d;
    end
  end

  // Expected-address delay line, aligned with the RAM read latency.
  always_comb begin
    dl_vld_d     = dl_vld_q;
    dl_addr_d    = dl_addr_q;
    dl_vld_d[0]  = (state_q == S_READ);
    dl_addr_d[0] = a_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_addr_d[i] = dl_addr_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    seed_d  = seed_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
    drain_d = drain_q;

    if (mismatch) begin
      if (err_q != ERR_MAX) err_d = err_q + 1'b1;
      if (err_q == '0)      first_d = cmp_addr;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          seed_d  = seed;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          a_d     = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        a_d = a_q + 1'b1;
        if (a_q == A_LAST) begin
          a_d     = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d = a_q + 1'b1;
        if (a_q == A_LAST) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_FIN;
        else                       drain_d = drain_q + 1'b1;
      end
      S_FIN: begin
        // Final compare has already landed in err_q by the time FIN is reached.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign chipselect     = (state_q == S_WRITE) || (state_q == S_READ);
  assign write          = (state_q == S_WRITE);
  assign address        = chipselect ? a_q : '0;
  assign writedata      = write ? pattern(seed_q, a_q) : '0;
  assign byteenable     = chipselect ? '1 : '0;
  assign clken          = ~reset;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_platform_ram_tester.sv
// Bench for platform_ram_tester: behavioural 1-cycle RAMs, random seeds and corruption,
// expected results queued at start and checked by a monitor when done pulses.
module tb_platform_ram_tester;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int RL    = 1;
  localparam int EW    = 16;
  localparam int EW_S  = 2;
  localparam int DEPTH = 16;
  localparam logic [31:0] GOLDEN = 32'h9E3779B1;

  typedef struct {
    logic          pass;
    int            err;
    logic [AW-1:0] first;
    int            cyc;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;

  logic          busy, done, pass, chipselect, write, clken;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr, address;
  logic [3:0]    byteenable;
  logic [DW-1:0] writedata, readdata;
  logic [2:0]    dbg_state;

  logic            s_busy, s_done, s_pass, s_chipselect, s_write, s_clken;
  logic [EW_S-1:0] s_err_count;
  logic [AW-1:0]   s_first_err_addr, s_address;
  logic [3:0]      s_byteenable;
  logic [DW-1:0]   s_writedata, s_readdata;
  logic [2:0]      s_dbg_state;

  platform_ram_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write), .writedata(writedata), .clken(clken),
    .readdata(readdata), .dbg_state(dbg_state)
  );

  platform_ram_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .ERR_W(EW_S)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
    .first_err_addr(s_first_err_addr), .address(s_address), .byteenable(s_byteenable),
    .chipselect(s_chipselect), .write(s_write), .writedata(s_writedata), .clken(s_clken),
    .readdata(s_readdata), .dbg_state(s_dbg_state)
  );

  // RAM models: registered read address, unregistered data, corruption applied on read
  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] mask  [DEPTH];
  logic [DW-1:0] s_mem [DEPTH];
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] s_rd_addr = '0;

  always @(posedge clk) begin
    if (clken && chipselect) begin
      if (write) mem[address] <= writedata;
      else       rd_addr <= address;
    end
    if (s_clken && s_chipselect) begin
      if (s_write) s_mem[s_address] <= s_writedata;
      else         s_rd_addr <= s_address;
    end
  end
  assign readdata   = mem[rd_addr] ^ mask[rd_addr];
  assign s_readdata = s_mem[s_rd_addr] ^ 32'h1;

  // scoreboard
  exp_t exp_q[$];
  exp_t s_exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] cur_seed = '0;
  logic [AW-1:0] next_addr = '0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  function automatic logic [DW-1:0] pat(input logic [DW-1:0] s, input int a);
    logic [63:0] p;
    p = 64'(a) * 64'(GOLDEN);
    return s ^ p[31:0];
  endfunction

  function automatic exp_t build(input int n, input int first, input int errw);
    exp_t e;
    int sat;
    sat     = (2 ** errw) - 1;
    e.err   = (n > sat) ? sat : n;
    e.first = AW'(first);
    e.pass  = (n == 0);
    e.cyc   = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (chipselect) begin
        check("bus_address", 64'(address), 64'(next_addr));
        check("byteenable", 64'(byteenable), 64'h000F);
        if (write) begin
          check("writedata", 64'(writedata), 64'(pat(cur_seed, int'(address))));
          wr_cnt++;
        end else begin
          rd_cnt++;
        end
        next_addr = next_addr + 1'b1;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with no test outstanding (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pass", 64'(pass), 64'(mon_e.pass));
          check("err_count", 64'(err_count), 64'(mon_e.err));
          check("first_err_addr", 64'(first_err_addr), 64'(mon_e.first));
          check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("write_count", 64'(wr_cnt), 64'(DEPTH));
          check("read_count", 64'(rd_cnt), 64'(DEPTH));
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
      if (s_done) begin
        if (s_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sat_unexpected_done: done=1 with no test outstanding (cycle %0d)", cyc);
        end else begin
          mon_e = s_exp_q.pop_front();
          check("sat_pass", 64'(s_pass), 64'(mon_e.pass));
          check("sat_err_count", 64'(s_err_count), 64'(mon_e.err));
          check("sat_first_err_addr", 64'(s_first_err_addr), 64'(mon_e.first));
          check("sat_done_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end

  // driver tasks
  task automatic clear_mask();
    for (int i = 0; i < DEPTH; i++) mask[i] = '0;
  endtask

  task automatic do_start(input logic [DW-1:0] s, input bit accepted, input bit push);
    exp_t e;
    int n;
    int first;
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    if (accepted) begin
      cur_seed  = s;
      next_addr = '0;
      wr_cnt    = 0;
      rd_cnt    = 0;
    end
    if (push) begin
      n = 0;
      first = 0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (mask[i] != '0) begin
          n++;
          first = i;
        end
      end
      e = build(n, first, EW);
      e.cyc = cyc + 1 + 2 * DEPTH + RL + 1;
      exp_q.push_back(e);
      e = build(DEPTH, 0, EW_S);
      e.cyc = cyc + 1 + 2 * DEPTH + RL + 1;
      s_exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    seed  = $urandom;
    if (accepted) check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || s_exp_q.size() != 0); i++) @(posedge clk);
    if (exp_q.size() != 0 || s_exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d/%0d results outstanding", exp_q.size(), s_exp_q.size());
      exp_q.delete();
      s_exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clear_mask();
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_first_err_addr", 64'(first_err_addr), 64'd0);
    check("rst_address", 64'(address), 64'd0);
    check("rst_chipselect", 64'(chipselect), 64'd0);
    check("rst_write", 64'(write), 64'd0);
    check("rst_writedata", 64'(writedata), 64'd0);
    check("rst_byteenable", 64'(byteenable), 64'd0);
    check("rst_clken", 64'(clken), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("clken_run", 64'(clken), 64'd1);

    // clean pass with zero seed
    do_start(32'h0, 1'b1, 1'b1);
    wait_idle();

    // single-bit corruption of word 5
    mask[5] = 32'h1;
    do_start($urandom, 1'b1, 1'b1);
    wait_idle();

    // words 3, 9, 15 corrupted (15 is the last read before the phase wrap)
    clear_mask();
    mask[3]  = 32'h1 << $urandom_range(31, 0);
    mask[9]  = 32'h1 << $urandom_range(31, 0);
    mask[15] = 32'h1 << $urandom_range(31, 0);
    do_start($urandom, 1'b1, 1'b1);
    wait_idle();

    // start pulses while busy and in the done cycle are ignored
    clear_mask();
    do_start($urandom, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      do_start($urandom, 1'b0, 1'b0);
    end
    begin
      int t;
      for (t = 0; t < 100; t++) begin
        @(negedge clk);
        if (done) break;
      end
      if (t == 100) begin
        checks++;
        errors++;
        $display("FAIL done_wait: no done within 100 cycles");
      end
      start = 1'b1;
      seed  = $urandom;
      @(negedge clk);
      start = 1'b0;
      check("start_with_done_busy", 64'(busy), 64'd0);
      check("start_with_done_cs", 64'(chipselect), 64'd0);
      repeat (3) @(negedge clk);
      check("start_with_done_idle", 64'(busy), 64'd0);
    end
    wait_idle();

    // reset in the 7th write cycle
    mask[2] = 32'h4;
    do_start($urandom, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_chipselect", 64'(chipselect), 64'd0);
    check("midrst_write", 64'(write), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err_count", 64'(err_count), 64'd0);
    check("midrst_first_err_addr", 64'(first_err_addr), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_clken", 64'(clken), 64'd0);
    check("midrst_sat_chipselect", 64'(s_chipselect), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_mask();
    repeat (2) @(negedge clk);
    do_start(32'hA5A5A5A5, 1'b1, 1'b1);
    wait_idle();

    // randomized corruption patterns
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < DEPTH; i++)
        mask[i] = ($urandom_range(3, 0) == 0) ? (32'h1 << $urandom_range(31, 0)) : 32'h0;
      do_start($urandom, 1'b1, 1'b1);
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
